// File: rtl/region_bbox_stat_pkg.sv
// Shared constants for region_bbox_stat: box field layout, accumulator init values
// and the class-index width helper.
package region_bbox_pkg;

  // Field slots inside one channel word {x_min, y_min, x_max, y_max}; slot 0 is the LSB field.
  localparam int unsigned Y_MAX_SLOT = 0;
  localparam int unsigned X_MAX_SLOT = 1;
  localparam int unsigned Y_MIN_SLOT = 2;
  localparam int unsigned X_MIN_SLOT = 3;
  localparam int unsigned BOX_FIELDS = 4;

  // Empty accumulator: min fields filled with ones, max fields with zeros.
  localparam logic MIN_INIT_BIT = 1'b1;
  localparam logic MAX_INIT_BIT = 1'b0;

  function automatic int unsigned box_off(input int unsigned slot, input int unsigned coord_w);
    return slot * coord_w;
  endfunction

  function automatic int unsigned cls_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/region_bbox_stat_acc_ch.sv
// One channel's bounding-box / pixel-count accumulator.
// load (start a new frame from the current pixel) wins over init, which wins over upd.
module bbox_acc_ch
  import region_bbox_pkg::*;
#(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned CNT_W   = 20
) (
  input  logic               video_clk,
  input  logic               rst,
  input  logic               init,
  input  logic               load,
  input  logic               upd,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   cnt
);

  always_ff @(posedge video_clk) begin
    if (rst || (init && !load)) begin
      x_min <= {COORD_W{MIN_INIT_BIT}};
      y_min <= {COORD_W{MIN_INIT_BIT}};
      x_max <= {COORD_W{MAX_INIT_BIT}};
      y_max <= {COORD_W{MAX_INIT_BIT}};
      cnt   <= '0;
    end else if (load) begin
      x_min <= x;
      y_min <= y;
      x_max <= x;
      y_max <= y;
      cnt   <= CNT_W'(1);
    end else if (upd) begin
      if (x < x_min) x_min <= x;
      if (y < y_min) y_min <= y;
      if (x > x_max) x_max <= x;
      if (y > y_max) y_max <= y;
      // Saturating pixel count
      if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/region_bbox_stat.sv
// Per-frame bounding box and pixel count for NUM_CH pixel classes, published on the vs edge.
// Optional REGION_BBOX_ROI_CLIP_EN: only pixels inside roi_in (sampled per frame edge) accumulate.
module region_bbox_stat
  import region_bbox_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned MIN_PIX = 16,
  parameter bit          VS_POL  = 1'b1
) (
  input  logic                                   video_clk,
  input  logic                                   rst,
  input  logic                                   vs_in,
  input  logic                                   de_in,
  input  logic                                   hit_in,
  input  logic [cls_width(NUM_CH)-1:0]           cls_in,
  input  logic [COORD_W-1:0]                     x_in,
  input  logic [COORD_W-1:0]                     y_in,
  input  logic [BOX_FIELDS*COORD_W-1:0]          roi_in,
  output logic [NUM_CH*BOX_FIELDS*COORD_W-1:0]   loc_out,
  output logic [NUM_CH*CNT_W-1:0]                cnt_out,
  output logic [NUM_CH-1:0]                      box_valid,
  output logic                                   frame_done
);

  localparam int unsigned CLS_W = cls_width(NUM_CH);
  localparam int unsigned BOX_W = BOX_FIELDS * COORD_W;

  logic               vs_r;
  logic               vs_d;
  logic               de_r;
  logic               hit_r;
  logic [CLS_W-1:0]   cls_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;

  // Input register stage plus vs delay for edge detection
  always_ff @(posedge video_clk) begin
    if (rst) begin
      vs_r  <= ~VS_POL;
      vs_d  <= ~VS_POL;
      de_r  <= 1'b0;
      hit_r <= 1'b0;
      cls_r <= '0;
      x_r   <= '0;
      y_r   <= '0;
    end else begin
      vs_r  <= vs_in;
      vs_d  <= vs_r;
      de_r  <= de_in;
      hit_r <= hit_in;
      cls_r <= cls_in;
      x_r   <= x_in;
      y_r   <= y_in;
    end
  end

  logic edge_c;
  assign edge_c = (vs_r == VS_POL) && (vs_d != VS_POL);

  logic roi_ok_c;
`ifdef REGION_BBOX_ROI_CLIP_EN
  logic [BOX_W-1:0]   roi_q;
  logic [BOX_W-1:0]   roi_c;
  logic [COORD_W-1:0] rx0_c;
  logic [COORD_W-1:0] ry0_c;
  logic [COORD_W-1:0] rx1_c;
  logic [COORD_W-1:0] ry1_c;

  // Window latched per frame; until the first edge after reset the whole frame is open
  always_ff @(posedge video_clk) begin
    if (rst) begin
      roi_q <= {{COORD_W{1'b0}}, {COORD_W{1'b0}}, {COORD_W{1'b1}}, {COORD_W{1'b1}}};
    end else if (edge_c) begin
      roi_q <= roi_in;
    end
  end

  // A pixel arriving with the edge belongs to the new frame, so it sees the new window
  assign roi_c    = edge_c ? roi_in : roi_q;
  assign rx0_c    = roi_c[box_off(X_MIN_SLOT, COORD_W) +: COORD_W];
  assign ry0_c    = roi_c[box_off(Y_MIN_SLOT, COORD_W) +: COORD_W];
  assign rx1_c    = roi_c[box_off(X_MAX_SLOT, COORD_W) +: COORD_W];
  assign ry1_c    = roi_c[box_off(Y_MAX_SLOT, COORD_W) +: COORD_W];
  assign roi_ok_c = (x_r >= rx0_c) && (x_r <= rx1_c) && (y_r >= ry0_c) && (y_r <= ry1_c);
`else
  logic unused_roi;
  assign unused_roi = ^roi_in;
  assign roi_ok_c   = 1'b1;
`endif

  logic pix_c;
  assign pix_c = de_r && hit_r && (32'(cls_r) < NUM_CH) && roi_ok_c;

  logic [COORD_W-1:0]       x_min_a [NUM_CH];
  logic [COORD_W-1:0]       y_min_a [NUM_CH];
  logic [COORD_W-1:0]       x_max_a [NUM_CH];
  logic [COORD_W-1:0]       y_max_a [NUM_CH];
  logic [CNT_W-1:0]         cnt_a   [NUM_CH];
  logic [NUM_CH*BOX_W-1:0]  loc_nxt_c;
  logic [NUM_CH*CNT_W-1:0]  cnt_nxt_c;
  logic [NUM_CH-1:0]        valid_nxt_c;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic hit_ch_c;
    logic empty_c;

    assign hit_ch_c = pix_c && (cls_r == CLS_W'(c));
    assign empty_c  = (cnt_a[c] == '0);

    bbox_acc_ch #(
      .COORD_W (COORD_W),
      .CNT_W   (CNT_W)
    ) u_acc (
      .video_clk (video_clk),
      .rst       (rst),
      .init      (edge_c),
      .load      (edge_c && hit_ch_c),
      .upd       (hit_ch_c),
      .x         (x_r),
      .y         (y_r),
      .x_min     (x_min_a[c]),
      .y_min     (y_min_a[c]),
      .x_max     (x_max_a[c]),
      .y_max     (y_max_a[c]),
      .cnt       (cnt_a[c])
    );

    // An empty channel reports a zero box rather than the init sentinels
    assign loc_nxt_c[c*BOX_W + box_off(X_MIN_SLOT, COORD_W) +: COORD_W] = empty_c ? '0 : x_min_a[c];
    assign loc_nxt_c[c*BOX_W + box_off(Y_MIN_SLOT, COORD_W) +: COORD_W] = empty_c ? '0 : y_min_a[c];
    assign loc_nxt_c[c*BOX_W + box_off(X_MAX_SLOT, COORD_W) +: COORD_W] = empty_c ? '0 : x_max_a[c];
    assign loc_nxt_c[c*BOX_W + box_off(Y_MAX_SLOT, COORD_W) +: COORD_W] = empty_c ? '0 : y_max_a[c];
    assign cnt_nxt_c[c*CNT_W +: CNT_W] = cnt_a[c];
    assign valid_nxt_c[c]              = (32'(cnt_a[c]) >= MIN_PIX);
  end

  // Publish the finished frame on the edge; results hold for the whole next frame
  always_ff @(posedge video_clk) begin
    if (rst) begin
      loc_out    <= '0;
      cnt_out    <= '0;
      box_valid  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= edge_c;
      if (edge_c) begin
        loc_out   <= loc_nxt_c;
        cnt_out   <= cnt_nxt_c;
        box_valid <= valid_nxt_c;
      end
    end
  end

endmodule

// File: doc/region_bbox_stat.md
Name: region_bbox_stat

Overview:
- Per-frame bounding-box and pixel-count extractor for NUM_CH independent pixel classes (labels or colour classes) on the processed video stream.
- Sits after labelling/threshold stages in the video_clk domain; feeds box overlay and host logic.
- Generalises the fixed three-box location outputs to a parametrised channel count, with a per-channel minimum-size validity and a frame-done strobe.

Parameters:
- NUM_CH, 4, number of tracked classes/regions (1..16)
- COORD_W, 12, width of x/y coordinates
- CNT_W, 20, pixel-count width; the count saturates at the maximum value
- MIN_PIX, 16, minimum pixel count for a channel box to be flagged valid
- VS_POL, 1, active level of vs_in; the frame boundary is the edge into the active level

Ports:
- video_clk  in  1  pixel clock; the single clock for the block
- rst  in  1  synchronous, active-high reset
- vs_in  in  1  frame sync
- de_in  in  1  pixel valid
- hit_in  in  1  pixel belongs to a class (qualified by de_in)
- cls_in  in  $clog2(NUM_CH) (min 1)  class index of the pixel
- x_in  in  COORD_W  pixel x
- y_in  in  COORD_W  pixel y
- roi_in  in  4*COORD_W  {x0,y0,x1,y1}; used only with ROI_CLIP_EN
- loc_out  out  NUM_CH*4*COORD_W  per channel {x_min,y_min,x_max,y_max}, channel 0 in the LSBs
- cnt_out  out  NUM_CH*CNT_W  per-channel pixel count of the last frame
- box_valid  out  NUM_CH  count ≥ MIN_PIX for the last frame
- frame_done  out  1  one-cycle pulse when the outputs update

Behaviour:
- Reset (rst=1 at a video_clk edge):
  - All outputs go to 0.
  - Accumulators: min = all ones, max = 0, count = 0.
  - The vs delay register is loaded with the inactive level.
- Input stage: one register stage on vs/de/hit/cls/x/y.
- Frame edge detection: on the registered signals, asserts when vs_r = VS_POL and vs_d ≠ VS_POL.
- Accumulate:
  - Condition: de_r & hit_r & cls_r < NUM_CH.
  - Channel cls_r updates: x_min = min(x_min, x), x_max = max(x_max, x), and likewise for y.
  - Count increments by 1, saturating at 2^CNT_W-1.
  - cls_r ≥ NUM_CH is ignored; no channel changes.
- Frame edge, in one cycle:
  - Each channel's accumulator is copied to loc_out/cnt_out.
  - box_valid[c] = (count ≥ MIN_PIX).
  - A channel with count = 0 outputs loc = 0.
  - Accumulators are re-initialised.
  - frame_done pulses high for 1 cycle.
- Latency:
  - frame_done and the outputs change 2 cycles after the vs_in transition: 1 cycle input register, 1 cycle edge/update register.
  - Outputs hold stable for the whole following frame.
- Simultaneous event: a qualifying pixel registered in the same cycle as the frame edge is accumulated into the NEW frame. Its channel is initialised directly with that pixel: min = max = pixel, count = 1.
- Two frame edges with no pixels in between: all box_valid = 0, cnt_out = 0, and frame_done still pulses.
- Reset mid-frame: partial accumulation is discarded. The first frame after reset reports only pixels seen after reset.
- No backpressure: the block accepts a pixel every cycle.

Optional Feature:
- Macro: REGION_BBOX_ROI_CLIP_EN.
- Defined: roi_in is sampled at each frame edge. A pixel accumulates only if x0 ≤ x ≤ x1 and y0 ≤ y ≤ y1, inclusive. If x0 > x1 or y0 > y1, no pixel accumulates.
- Undefined: roi_in is unused and all qualifying pixels accumulate.

Decomposition:
- Package region_bbox_pkg holds:
  - box field offsets (X_MIN/Y_MIN/X_MAX/Y_MAX slice positions)
  - the accumulator init constants
  - the class-index width function
- Sub-module bbox_acc_ch: one channel's min/max/count accumulator with init, update, and load-from-pixel controls, generated NUM_CH times.

Test Plan:
- Single square, cls=1, x 100..109, y 50..54, then frame edge:
  - loc ch1 = {100,50,109,54}, cnt ch1 = 50, box_valid = 4'b0010
  - frame_done pulses exactly 2 cycles after vs_in rises
- Frame with cls=2 holding only 10 pixels (MIN_PIX=16): cnt ch2 = 10 and box_valid[2] = 0; a 16-pixel frame gives box_valid[2] = 1.
- Pixel (7,9) cls=0 registered in the same cycle as the frame edge: the previous frame reports without it; the next frame reports ch0 = {7,9,7,9}, cnt = 1.
- Count saturation with CNT_W=4: 20 hits on ch0 gives cnt = 15, valid per MIN_PIX.
- Mid-frame rst pulse after 30 pixels, then 5 pixels, then an edge:
  - During reset, all outputs = 0.
  - After the edge, cnt = 5 only.
- With REGION_BBOX_ROI_CLIP_EN and roi = {10,10,20,20}: pixels at (5,5) and (15,15) give cnt = 1 and box = {15,15,15,15}; roi = {20,10,10,20} gives cnt = 0.
